band_mac_sequencer: RTL

Control block for the spectrum analyzer filter bank. It takes each audio sample strobe and runs the per-band IIR updates one band at a time through a single shared external multiplier, using a valid/ready request and a result-valid return. It holds the per-band coefficient and state registers, accumulates per-band energy over a fixed window, and publishes smoothed band energies to the PWM stage. It replaces four parallel multiplier pairs with one sequenced datapath.

---
 rtl/band_mac_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/band_mac_sequencer.sv
// Sequences per-band IIR updates through one shared external multiplier and
// publishes windowed, smoothed band energies. Optional build macro: BANDSEQ_SATURATE_EN.
module band_mac_sequencer #(
    parameter int NUM_BANDS   = 4,
    parameter int WINDOW      = 16,
    parameter int ENERGY_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_valid,
    input  logic [7:0]                       sample_data,
    output logic                             busy,
    output logic                             overrun,
    input  logic                             ovr_clr,
    output logic                             mul_valid,
    input  logic                             mul_ready,
    output logic [7:0]                       mul_a,
    output logic [15:0]                      mul_b,
    input  logic                             mul_result_valid,
    input  logic [23:0]                      mul_result,
    input  logic                             cfg_we,
    input  logic                             cfg_sel,
    input  logic [2:0]                       cfg_band,
    input  logic [7:0]                       cfg_data,
    output logic                             cfg_err,
    output logic [NUM_BANDS*ENERGY_BITS-1:0] band_energy,
    output logic                             energy_update
);
    localparam int BI = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int WW = $clog2(WINDOW);

    typedef enum logic [2:0] {IDLE, ISSUE_FB, WAIT_FB, ISSUE_FF, WAIT_FF, UPDATE} state_t;

    state_t                 state, state_nx;
    logic [BI-1:0]          band, band_nx;
    logic [7:0]             x;
    logic [7:0]             coef_a [NUM_BANDS];
    logic [7:0]             coef_b [NUM_BANDS];
    logic [15:0]            s_reg  [NUM_BANDS];
    logic [15:0]            y_reg  [NUM_BANDS];
    logic [ENERGY_BITS-1:0] acc    [NUM_BANDS];
    logic [ENERGY_BITS-1:0] energy [NUM_BANDS];
    logic [WW-1:0]          win_cnt;
    logic [15:0]            fb, ff;
    logic                   last_band, win_end, cfg_bad;
    logic                   mul_valid_d;
    logic [7:0]             mul_a_d, y_hi, y_mag;
    logic [15:0]            mul_b_d;
    logic [ENERGY_BITS-1:0] mag_ext, acc_new;
    logic                   unused_low_product;

    function automatic logic [7:0] def_a(int unsigned i);
        case (i)
            0: return 8'd20;
            1: return 8'd15;
            2: return 8'd10;
            3: return 8'd5;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] def_b(int unsigned i);
        case (i)
            0: return 8'd10;
            1: return 8'd25;
            2: return 8'd30;
            3: return 8'd40;
            default: return 8'd0;
        endcase
    endfunction

    assign unused_low_product = ^mul_result[7:0];
    assign last_band = (band == BI'(NUM_BANDS - 1));
    assign win_end   = (win_cnt == WW'(WINDOW - 1));
    assign cfg_bad   = cfg_we && (state != IDLE || sample_valid ||
                                  {29'b0, cfg_band} >= 32'(NUM_BANDS));

    // Energy contribution is |y_new[15:8]|, where y_new is the pre-update s[b].
    always_comb begin
        y_hi    = s_reg[band][15:8];
        y_mag   = y_hi[7] ? (8'd0 - y_hi) : y_hi;
        mag_ext = ENERGY_BITS'(y_mag);
    end

`ifdef BANDSEQ_SATURATE_EN
    logic [ENERGY_BITS:0] acc_sum;
    assign acc_sum = {1'b0, acc[band]} + {1'b0, mag_ext};
    assign acc_new = acc_sum[ENERGY_BITS] ? '1 : acc_sum[ENERGY_BITS-1:0];
`else
    assign acc_new = acc[band] + mag_ext;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            state     <= state_nx;
            mul_valid <= mul_valid_d;
            mul_a     <= mul_a_d;
            mul_b     <= mul_b_d;
        end
    end

    always_comb begin
        state_nx = state;
        band_nx  = band;
        case (state)
            IDLE:     if (sample_valid) begin
                          state_nx = ISSUE_FB;
                          band_nx  = '0;
                      end
            ISSUE_FB: if (mul_ready) state_nx = WAIT_FB;
            WAIT_FB:  if (mul_result_valid) state_nx = ISSUE_FF;
            ISSUE_FF: if (mul_ready) state_nx = WAIT_FF;
            WAIT_FF:  if (mul_result_valid) state_nx = UPDATE;
            UPDATE:   if (last_band) state_nx = IDLE;
                      else begin
                          state_nx = ISSUE_FB;
                          band_nx  = band + 1'b1;
                      end
            default:  state_nx = IDLE;
        endcase
    end

    // Operands are registered from the next state, so they are valid on entry and hold while stalled.
    always_comb begin
        busy        = (state != IDLE);
        mul_valid_d = 1'b0;
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        case (state_nx)
            ISSUE_FB: begin
                mul_valid_d = 1'b1;
                mul_a_d     = coef_a[band_nx];
                mul_b_d     = y_reg[band_nx];
            end
            ISSUE_FF: begin
                mul_valid_d = 1'b1;
                mul_a_d     = coef_b[band_nx];
                mul_b_d     = {{8{x[7]}}, x};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            band          <= '0;
            x             <= '0;
            fb            <= '0;
            ff            <= '0;
            win_cnt       <= '0;
            overrun       <= 1'b0;
            cfg_err       <= 1'b0;
            energy_update <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                coef_a[i] <= def_a(i);
                coef_b[i] <= def_b(i);
                s_reg[i]  <= '0;
                y_reg[i]  <= '0;
                acc[i]    <= '0;
                energy[i] <= '0;
            end
        end else begin
            band          <= band_nx;
            energy_update <= 1'b0;
            cfg_err       <= cfg_bad;
            if (sample_valid && state != IDLE) overrun <= 1'b1;
            else if (ovr_clr)                  overrun <= 1'b0;
            if (cfg_we && !cfg_bad) begin
                if (cfg_sel) coef_b[cfg_band[BI-1:0]] <= cfg_data;
                else         coef_a[cfg_band[BI-1:0]] <= cfg_data;
            end
            case (state)
                IDLE:    if (sample_valid) x <= sample_data;
                WAIT_FB: if (mul_result_valid) fb <= mul_result[23:8];
                WAIT_FF: if (mul_result_valid) ff <= mul_result[23:8];
                UPDATE: begin
                    s_reg[band] <= s_reg[band] - fb + ff;
                    y_reg[band] <= s_reg[band];
                    if (last_band && win_end) begin
                        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                            energy[i] <= (energy[i] >> 1) +
                                         ((BI'(i) == band ? acc_new : acc[i]) >> 1);
                            acc[i]    <= '0;
                        end
                        win_cnt       <= '0;
                        energy_update <= 1'b1;
                    end else begin
                        acc[band] <= acc_new;
                        if (last_band) win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        band_energy = '0;
        for (int unsigned i = 0; i < NUM_BANDS; i++)
            band_energy[i*ENERGY_BITS +: ENERGY_BITS] = energy[i];
    end
endmodule
